// File: rtl/delay_bist_ctrl_pkg.sv
// Shared definitions for the delay-line BIST controller.
//   bist_state_e  : controller FSM state encoding
//   DEPTH_DEFAULT : default number of delay-line stages
//   NO_ERR_IDX    : first_err_idx value when no mismatch was seen
//   CNT_W         : width of the pattern/compare cycle counter
package delay_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } bist_state_e;

  localparam int unsigned DEPTH_DEFAULT = 33;
  localparam logic [7:0]  NO_ERR_IDX    = 8'hFF;
  // n runs up to num_vec + tap = 255 + 63, so 9 bits are needed.
  localparam int unsigned CNT_W         = 9;

  // Saturating 8-bit increment for the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bist_vec_cnt.sv
// Pattern/compare index counter for the delay-line BIST.
// Counts the RUN+DRAIN cycle index n and derives the compare index
// j = n - tap - 1 together with its validity window 0 <= j < num_vec.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : reload n to 0
//   en        : advance n by one
//   tap       : latched tap under test
//   num_vec   : latched number of vectors
//   pat_off   : n truncated to the sample width (pattern offset)
//   j         : compare index (valid only when j_valid)
//   j_valid   : current cycle carries a compare
//   run_last  : n == num_vec-1 (last stimulus cycle)
//   cmp_last  : current compare is the final one (j == num_vec-1)
module bist_vec_cnt
  import delay_bist_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [5:0]       tap,
  input  logic [7:0]       num_vec,
  output logic [WIDTH-1:0] pat_off,
  output logic [7:0]       j,
  output logic             j_valid,
  output logic             run_last,
  output logic             cmp_last
);

  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] j_full;

  always_comb begin
    n_d = n_q;
    if (clr) begin
      n_d = '0;
    end else if (en) begin
      n_d = n_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_q <= '0;
    end else begin
      n_q <= n_d;
    end
  end

  // j wraps when n <= tap; the n > tap term masks that case out.
  assign j_full   = n_q - {3'b000, tap} - CNT_W'(1);
  assign j_valid  = (n_q > {3'b000, tap}) && (j_full < {1'b0, num_vec});
  assign j        = j_full[7:0];
  assign pat_off  = WIDTH'(n_q);
  assign run_last = (n_q == ({1'b0, num_vec} - CNT_W'(1)));
  assign cmp_last = j_valid && (j_full[7:0] == (num_vec - 8'd1));

endmodule

// File: rtl/delay_bist_ctrl.sv
// BIST controller for an external tapped delay line.
// Drives an incrementing pattern seed+n into the line, compares the selected
// tap output against the expected delayed pattern and reports results.
//   clk, rstn     : clock, asynchronous active-low reset
//   start, abort  : test request (IDLE only) / synchronous cancel
//   tap_sel       : tap under test; num_vec : vector count; seed : first value
//   dl_clr        : one-cycle clear strobe to the delay line
//   dl_din        : stimulus to the delay line; dl_tap : tap select
//   dl_dout       : selected tap output from the delay line
//   busy, done, pass, cfg_err, aborted, err_cnt, first_err_idx : status
module delay_bist_ctrl
  import delay_bist_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [5:0]              tap_sel,
  input  logic [7:0]              num_vec,
  input  logic signed [WIDTH-1:0] seed,
  output logic                    dl_clr,
  output logic signed [WIDTH-1:0] dl_din,
  output logic [5:0]              dl_tap,
  input  logic signed [WIDTH-1:0] dl_dout,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    cfg_err,
  output logic                    aborted,
  output logic [7:0]              err_cnt,
  output logic [7:0]              first_err_idx
);

  bist_state_e state_q, state_d;

  logic [5:0]              tap_q, tap_d;
  logic [7:0]              nv_q, nv_d;
  logic signed [WIDTH-1:0] seed_q, seed_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [7:0]              fe_q, fe_d;
  logic                    pass_q, pass_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    aborted_q, aborted_d;

  logic             cnt_clr, cnt_en;
  logic [WIDTH-1:0] pat_off;
  logic [7:0]       j;
  logic             j_valid, run_last, cmp_last;
  logic             tap_bad;
  logic             mismatch;
  logic [WIDTH-1:0] exp_val;

  assign cnt_clr = (state_q == StIdle) && start;
  assign cnt_en  = (state_q == StRun) || (state_q == StDrain);
  assign tap_bad = 32'(tap_sel) > (DEPTH - 32'd1);

  bist_vec_cnt #(
    .WIDTH (WIDTH)
  ) u_vec_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .tap      (tap_q),
    .num_vec  (nv_q),
    .pat_off  (pat_off),
    .j        (j),
    .j_valid  (j_valid),
    .run_last (run_last),
    .cmp_last (cmp_last)
  );

  // A cancelled cycle does not contribute a compare result.
  assign exp_val  = seed_q + WIDTH'(j);
  assign mismatch = cnt_en && j_valid && !abort && ($unsigned(dl_dout) != exp_val);

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    nv_d      = nv_q;
    seed_d    = seed_q;
    err_cnt_d = err_cnt_q;
    fe_d      = fe_q;
    pass_d    = pass_q;
    cfg_err_d = cfg_err_q;
    aborted_d = aborted_q;

    if (mismatch) begin
      err_cnt_d = sat_inc8(err_cnt_q);
      if (err_cnt_q == 8'd0) begin
        fe_d = j;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tap_d     = tap_sel;
          nv_d      = num_vec;
          seed_d    = seed;
          err_cnt_d = 8'd0;
          fe_d      = NO_ERR_IDX;
          pass_d    = 1'b0;
          cfg_err_d = 1'b0;
          aborted_d = 1'b0;
          if (tap_bad) begin
            cfg_err_d = 1'b1;
            state_d   = StDone;
          end else if (num_vec == 8'd0) begin
            pass_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StClear;
          end
        end
      end
      StClear, StRun, StDrain: begin
        if (abort) begin
          aborted_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = StIdle;
        end else if (state_q == StClear) begin
          state_d = StRun;
        end else if (state_q == StRun) begin
          if (run_last) begin
            state_d = StDrain;
          end
        end else if (cmp_last) begin
          // err_cnt_d already holds this cycle's final compare.
          pass_d  = (err_cnt_d == 8'd0) && !cfg_err_q;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      tap_q     <= '0;
      nv_q      <= '0;
      seed_q    <= '0;
      err_cnt_q <= '0;
      fe_q      <= NO_ERR_IDX;
      pass_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      nv_q      <= nv_d;
      seed_q    <= seed_d;
      err_cnt_q <= err_cnt_d;
      fe_q      <= fe_d;
      pass_q    <= pass_d;
      cfg_err_q <= cfg_err_d;
      aborted_q <= aborted_d;
    end
  end

  assign dl_clr        = (state_q == StClear);
  assign dl_din        = (state_q == StRun) ? (seed_q + pat_off) : '0;
  assign dl_tap        = tap_q;
  assign busy          = (state_q == StClear) || cnt_en;
  assign done          = (state_q == StDone);
  assign pass          = pass_q;
  assign cfg_err       = cfg_err_q;
  assign aborted       = aborted_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = fe_q;

endmodule
